// File: rtl/bus_arbiter_pkg.sv
// Shared types and constants for the round-robin system-bus arbiter.
package bus_arbiter_pkg;

   localparam int MAX_MASTERS    = 8;
   localparam int INDEX_WIDTH    = 3;
   localparam int WATCHDOG_WIDTH = 16;

   typedef logic [INDEX_WIDTH-1:0]    masterIndex_t;
   typedef logic [WATCHDOG_WIDTH-1:0] watchdog_t;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      GRANTED = 3'd1,
      BUSY    = 3'd2,
      RELEASE = 3'd3,
      TIMEOUT = 3'd4
   } arbState_e;

   // Index of the master after 'index', wrapping to 0 after count-1.
   function automatic masterIndex_t nextIndex(input masterIndex_t index, input int unsigned count);
      return (32'(index) == count - 1) ? '0 : index + 1'b1;
   endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Arbitration and transaction-control lines between the bus masters and the arbiter.
interface bus_arbiter_if
   import bus_arbiter_pkg::*;
#(
   parameter int nrOfMasters = 4
);

   logic [nrOfMasters-1:0] requests;
   logic [nrOfMasters-1:0] grants;
   logic                   beginTransactionIn;
   logic                   endTransactionIn;
   logic                   dataValidIn;
   logic                   endTransactionOut;
   logic                   busErrorOut;
   masterIndex_t           activeMaster;

   // master: the requesters' side; slave: the arbiter's side.
   modport master (
      output requests, beginTransactionIn, endTransactionIn, dataValidIn,
      input  grants, endTransactionOut, busErrorOut, activeMaster
   );

   modport slave (
      input  requests, beginTransactionIn, endTransactionIn, dataValidIn,
      output grants, endTransactionOut, busErrorOut, activeMaster
   );

endinterface

// File: rtl/bus_arbiter_rr_priority_select.sv
// Combinational round-robin selector: first set request at or above the pointer, wrapping.
module rr_priority_select
   import bus_arbiter_pkg::*;
#(
   parameter int nrOfMasters = 4
) (
   input  logic [nrOfMasters-1:0] requests,
   input  masterIndex_t           pointer,
   output masterIndex_t           selected,
   output logic                   valid
);

   logic [MAX_MASTERS-1:0] paddedRequests;
   logic [INDEX_WIDTH:0]   candidate;

   // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
   always_comb begin
      paddedRequests = MAX_MASTERS'(requests);
      candidate      = '0;
      selected       = '0;
      valid          = 1'b0;
      for (int offset = 0; offset < nrOfMasters; offset++) begin
         candidate = {1'b0, pointer} + (INDEX_WIDTH+1)'(offset);
         if (candidate >= (INDEX_WIDTH+1)'(nrOfMasters)) begin
            candidate = candidate - (INDEX_WIDTH+1)'(nrOfMasters);
         end
         if (!valid && paddedRequests[candidate[INDEX_WIDTH-1:0]]) begin
            selected = candidate[INDEX_WIDTH-1:0];
            valid    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with a one-hot registered grant held until end of transaction,
// plus a watchdog that aborts stalled transactions with a single-cycle bus error.
module bus_arbiter
   import bus_arbiter_pkg::*;
#(
   parameter int nrOfMasters   = 4,
   parameter int timeoutCycles = 1024
) (
   input logic          clock,
   input logic          reset,
   bus_arbiter_if.slave bus
);

   localparam watchdog_t watchdogReload = WATCHDOG_WIDTH'(timeoutCycles - 1);

   arbState_e              state,        stateNext;
   masterIndex_t           pointer,      pointerNext;
   watchdog_t              watchdog,     watchdogNext;
   logic [nrOfMasters-1:0] grants,       grantsNext;
   masterIndex_t           activeMaster, activeMasterNext;
   logic                   busError,     busErrorNext;
   logic                   expire;
   masterIndex_t           selected;
   logic                   selectedValid;

   rr_priority_select #(
      .nrOfMasters(nrOfMasters)
   ) prioritySelect (
      .requests(bus.requests),
      .pointer (pointer),
      .selected(selected),
      .valid   (selectedValid)
   );

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         pointer      <= '0;
         watchdog     <= watchdogReload;
         grants       <= '0;
         activeMaster <= '0;
         busError     <= 1'b0;
      end else begin
         state        <= stateNext;
         pointer      <= pointerNext;
         watchdog     <= watchdogNext;
         grants       <= grantsNext;
         activeMaster <= activeMasterNext;
         busError     <= busErrorNext;
      end
   end

   always_comb begin
      stateNext        = state;
      pointerNext      = pointer;
      watchdogNext     = watchdog;
      grantsNext       = grants;
      activeMasterNext = activeMaster;
      busErrorNext     = 1'b0;
      expire           = 1'b0;

      case (state)
         IDLE: begin
            if (selectedValid) begin
               stateNext        = GRANTED;
               grantsNext       = nrOfMasters'(1) << selected;
               activeMasterNext = selected;
               pointerNext      = nextIndex(selected, nrOfMasters);
               watchdogNext     = watchdogReload;
            end
         end

         GRANTED: begin
            if (bus.beginTransactionIn) begin
               stateNext    = BUSY;
               watchdogNext = watchdogReload;
            end else if (watchdog == '0) begin
               expire = 1'b1;
            end else begin
               watchdogNext = watchdog - 1'b1;
            end
         end

         BUSY: begin
            // A normal end wins over a watchdog expiring on the same edge.
            if (bus.endTransactionIn) begin
               stateNext        = RELEASE;
               grantsNext       = '0;
               activeMasterNext = '0;
            end else if (watchdog == '0) begin
               expire = 1'b1;
            end else if (bus.dataValidIn || bus.beginTransactionIn) begin
               watchdogNext = watchdogReload;
            end else begin
               watchdogNext = watchdog - 1'b1;
            end
         end

         RELEASE: stateNext = IDLE;

         TIMEOUT: stateNext = IDLE;

         default: begin
            stateNext        = IDLE;
            grantsNext       = '0;
            activeMasterNext = '0;
         end
      endcase

      // The pointer already moved past the stalled master when it was granted.
      if (expire) begin
         stateNext        = TIMEOUT;
         grantsNext       = '0;
         activeMasterNext = '0;
         busErrorNext     = 1'b1;
      end
   end

   assign bus.grants            = grants;
   assign bus.activeMaster      = activeMaster;
   assign bus.busErrorOut       = busError;
   assign bus.endTransactionOut = busError;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus randomized transactions
// checked against a transaction-level round-robin model.
module tb_bus_arbiter;
   import bus_arbiter_pkg::*;

   localparam int N = 4;
   localparam int T = 16;

   logic clock;
   logic reset;
   int   checks   = 0;
   int   failures = 0;
   int   modelPtr = 0;

   bus_arbiter_if #(.nrOfMasters(N)) bus ();

   bus_arbiter #(
      .nrOfMasters  (N),
      .timeoutCycles(T)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "simulation did not terminate");
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Spec rule: first set request scanning upward from the pointer, modulo N.
   function automatic int pickMaster(input logic [N-1:0] req, input int ptr);
      for (int k = 0; k < N; k++) begin
         int idx;
         idx = (ptr + k) % N;
         if (((req >> idx) & 1) != 0) return idx;
      end
      return -1;
   endfunction

   task automatic checkOutputs(input string tag, input logic [N-1:0] expGrants, input int expMaster,
                               input logic expPulse);
      check({tag, ".grants"}, 32'(bus.grants), 32'(expGrants));
      check({tag, ".activeMaster"}, 32'(bus.activeMaster), expMaster);
      check({tag, ".busError"}, 32'(bus.busErrorOut), 32'(expPulse));
      check({tag, ".endOut"}, 32'(bus.endTransactionOut), 32'(expPulse));
   endtask

   // Present requests while the arbiter is idle; grant must appear after the next edge.
   task automatic grantNext(input logic [N-1:0] req, output int m);
      bus.requests = req;
      m = pickMaster(req, modelPtr);
      tick();
      checkOutputs("grant", N'(32'(1) << m), m, 1'b0);
      modelPtr = (m + 1) % N;
   endtask

   // Begin, busyLen cycles of random data, end; then RELEASE and the idle gap cycle.
   task automatic transfer(input int m, input int busyLen);
      logic [N-1:0] held;
      held = N'(32'(1) << m);
      bus.beginTransactionIn = 1'b1;
      tick();
      bus.beginTransactionIn = 1'b0;
      repeat (busyLen) begin
         bus.dataValidIn = 1'($urandom_range(0, 1));
         tick();
      end
      bus.dataValidIn = 1'b0;
      checkOutputs("busy", held, m, 1'b0);
      bus.endTransactionIn = 1'b1;
      tick();
      bus.endTransactionIn = 1'b0;
      checkOutputs("release", '0, 0, 1'b0);
      tick();
      checkOutputs("gap", '0, 0, 1'b0);
   endtask

   initial begin
      int m;
      int fairOrder[6] = '{0, 1, 2, 3, 0, 1};
      logic [N-1:0] req;

      reset                  = 1'b0;
      bus.requests           = '0;
      bus.beginTransactionIn = 1'b0;
      bus.endTransactionIn   = 1'b0;
      bus.dataValidIn        = 1'b0;
      #23;
      checkOutputs("reset", '0, 0, 1'b0);
      @(negedge clock);
      reset = 1'b1;
      tick();
      checkOutputs("postReset", '0, 0, 1'b0);

      // Single requester; the request drop after grant is ignored.
      grantNext(4'b0100, m);
      bus.requests = '0;
      tick();
      tick();
      checkOutputs("held", 4'b0100, 2, 1'b0);
      bus.requests = 4'b0011;
      transfer(m, 10);

      // Pointer now 3: requests 0011 wrap around to master 0.
      grantNext(4'b0011, m);
      bus.requests = '0;
      transfer(m, 5);

      // No-begin timeout on master 1 while master 2 waits.
      grantNext(4'b0010, m);
      bus.requests = 4'b0100;
      for (int i = 1; i < T; i++) begin
         tick();
         checkOutputs("grantWait", 4'b0010, 1, 1'b0);
      end
      tick();
      checkOutputs("timeoutPulse", '0, 0, 1'b1);
      tick();
      checkOutputs("afterPulse", '0, 0, 1'b0);
      grantNext(4'b0100, m);
      bus.requests = '0;

      // Stalled burst: periodic dataValid keeps the watchdog alive, then stops.
      bus.beginTransactionIn = 1'b1;
      tick();
      bus.beginTransactionIn = 1'b0;
      for (int p = 0; p < 4; p++) begin
         repeat (9) begin
            tick();
            checkOutputs("stream", 4'b0100, 2, 1'b0);
         end
         bus.dataValidIn = 1'b1;
         tick();
         bus.dataValidIn = 1'b0;
      end
      for (int i = 1; i < T; i++) begin
         tick();
         checkOutputs("stall", 4'b0100, 2, 1'b0);
      end
      tick();
      checkOutputs("stallPulse", '0, 0, 1'b1);
      tick();
      checkOutputs("stallIdle", '0, 0, 1'b0);

      // End arriving on the expiry edge wins: no error pulse.
      grantNext(4'b1000, m);
      bus.requests = '0;
      bus.beginTransactionIn = 1'b1;
      tick();
      bus.beginTransactionIn = 1'b0;
      repeat (T - 1) tick();
      checkOutputs("preExpiry", 4'b1000, 3, 1'b0);
      bus.endTransactionIn = 1'b1;
      tick();
      bus.endTransactionIn = 1'b0;
      checkOutputs("endWins", '0, 0, 1'b0);
      tick();
      checkOutputs("endWinsIdle", '0, 0, 1'b0);

      // Asynchronous reset between edges while BUSY.
      req = N'($urandom_range(1, (1 << N) - 1));
      grantNext(req, m);
      bus.beginTransactionIn = 1'b1;
      tick();
      bus.beginTransactionIn = 1'b0;
      repeat (3) tick();
      #2;
      reset = 1'b0;
      #1;
      checkOutputs("asyncReset", '0, 0, 1'b0);
      modelPtr     = 0;
      bus.requests = 4'b1111;
      @(negedge clock);
      reset = 1'b1;

      // Fairness from a fresh pointer: strict rotation under full load.
      for (int i = 0; i < 6; i++) begin
         grantNext(4'b1111, m);
         check("fairOrder", 32'(bus.activeMaster), fairOrder[i]);
         transfer(m, 8);
      end

      // Randomized request patterns and transaction lengths.
      for (int i = 0; i < 30; i++) begin
         req = N'($urandom_range(1, (1 << N) - 1));
         grantNext(req, m);
         if ($urandom_range(0, 1) == 1) bus.requests = '0;
         transfer(m, int'($urandom_range(1, 12)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Round-robin arbiter for the shared system bus used by the camera grabber, the CPU data path and other bus masters. It receives one request line per master, issues a single one-hot grant, and holds it from grant through `endTransaction`. A watchdog terminates stalled or abandoned transactions with a bus error. It sits between the masters' `requestBus`/`busGrant` pins and the bus `beginTransaction`/`endTransaction`/`busError` lines.

## Interface
Parameters:
- `nrOfMasters`, 4: number of requesters; legal range 2..8.
- `timeoutCycles`, 1024: watchdog reload value; legal range 2..65535.

Ports:
- `clock`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `requests`  in  nrOfMasters  per-master bus request; bit i is master i's `requestBus`.
- `grants`  out  nrOfMasters  registered one-hot grant; bit i drives master i's `busGrant`.
- `beginTransactionIn`  in  1  OR of all masters' `beginTransactionOut`.
- `endTransactionIn`  in  1  OR of all masters' `endTransactionOut`.
- `dataValidIn`  in  1  OR of all masters' `dataValidOut`.
- `endTransactionOut`  out  1  registered; arbiter-forced end of transaction, asserted on timeout only.
- `busErrorOut`  out  1  registered; bus error to all masters, asserted on timeout only.
- `activeMaster`  out  3  registered index of the granted master; 0 when no master is granted.

## Operation
- **Reset values:** `grants`=0, `activeMaster`=0, `endTransactionOut`=0, `busErrorOut`=0, state IDLE, round-robin pointer=0, watchdog=`timeoutCycles`-1.
- **IDLE:**
  - If any `requests` bit is high, select the first set bit scanning upward from the pointer, wrapping at `nrOfMasters`-1 to 0.
  - Set `grants`/`activeMaster` to the selected master and go to GRANTED.
  - Set pointer = selected + 1, wrapping to 0 after `nrOfMasters`-1.
- **GRANTED:**
  - The grant is held. A request drop after grant is normal and is ignored.
  - `beginTransactionIn` → BUSY.
  - Watchdog reaching 0 → TIMEOUT.
- **BUSY:**
  - `endTransactionIn` → RELEASE.
  - The watchdog is reloaded on every cycle where `dataValidIn` or `beginTransactionIn` is high.
  - Watchdog reaching 0 → TIMEOUT.
  - `endTransactionIn` has priority over a simultaneous watchdog expiry.
- **RELEASE:**
  - `grants` is cleared on entry.
  - One dead cycle, then IDLE. This guarantees one bus-idle cycle between owners.
- **TIMEOUT:**
  - `grants` is cleared.
  - `busErrorOut`=1 and `endTransactionOut`=1 for exactly one cycle, then IDLE.
  - The pointer has already advanced, so the faulty master loses priority.
- **Watchdog:**
  - 16-bit down-counter, loaded with `timeoutCycles`-1 when entering GRANTED.
  - Decrements by 1 per cycle in GRANTED/BUSY unless reloaded.
  - Expiry is counter==0 in GRANTED/BUSY.
  - Saturates; it never wraps.
- **Illegal state encodings** return to IDLE with all outputs 0.
- **Reset mid-transaction:** all outputs clear immediately (asynchronous). Masters are required to share the same reset.

## Timing
- **Grant latency:** request high in IDLE at edge n → `grants` high after edge n+1. Request-to-grant is 1 cycle when the bus is idle.
- **Back-to-back ownership:** `endTransactionIn` at cycle n → grants=0 at n+1 (RELEASE) → IDLE at n+2 → next grant visible at n+3. Minimum 2 grant-free cycles between owners.
- **Timeout detection:** with no begin after grant, the error pulse occurs `timeoutCycles` cycles after grant. Grant drops on the same edge the pulse rises.
- **Signal relationships:**
  - `busErrorOut` and `endTransactionOut` are always coincident and single-cycle.
  - `grants` is never more than one-hot.
  - All outputs are registered with no combinational path from inputs.

## Structure
- Shared package `bus_arbiter_pkg`:
  - state encoding: IDLE, GRANTED, BUSY, RELEASE, TIMEOUT (3 bits)
  - `MAX_MASTERS`=8
  - watchdog width 16
- Sub-module `rr_priority_select`:
  - combinational
  - inputs: `requests` vector and pointer
  - outputs: selected index and a valid flag
  - the only instantiation

## Test plan
- **Single requester:** reset, master 2 requests at cycle 5 → `grants`=4'b0100, `activeMaster`=2 from cycle 6. Begin at 8, end at 20 → grants=0 at cycle 21, and no grant before cycle 23.
- **Fairness:** all 4 request continuously, each transaction 10 cycles → grant order 0,1,2,3,0,1 with no master granted twice in a row.
- **Wrap-around:** pointer=3 and requests=4'b0011 → master 0 granted, pointer becomes 1.
- **No-begin timeout:** `timeoutCycles`=16, grant master 1, never begin → 16 cycles after grant, `busErrorOut`=`endTransactionOut`=1 for one cycle, grants=0. Master 2 requesting is then granted 1 cycle after the pulse.
- **Stalled burst:**
  - Begin with `dataValidIn` pulsing every 10 cycles and `timeoutCycles`=16 → no timeout.
  - Stop `dataValidIn` → error pulse 16 cycles after the last valid.
  - `endTransactionIn` coincident with expiry → no error pulse.
- **Asynchronous reset:** assert `reset` low mid-BUSY between clock edges → `grants`, `activeMaster`, and both pulse outputs are 0 immediately. After release, first grant goes to the lowest-index requester.
